// File: rtl/spi_flash_read_seq.sv
// SPI-flash READ sequencer: drives the memory-mapped SPI controller through a
// full opcode/address/data transaction and streams received bytes over valid/ready.
module spi_flash_read_seq #(
    parameter logic [31:0] SPI_BASE    = 32'hd000,
    parameter logic [7:0]  READ_OPCODE = 8'h03,
    parameter int unsigned START_WAIT  = 2,
    parameter int unsigned CS_GAP      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [23:0] cmd_addr,
    input  logic [15:0] cmd_len,
    input  logic [3:0]  cmd_clkdiv,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        done,
    output logic        cs_n,
    output logic [31:0] spi_addr,
    output logic [31:0] spi_wdata,
    output logic [3:0]  spi_wmask,
    output logic        spi_wen,
    output logic        spi_ren,
    input  logic [31:0] spi_rdata
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned ADDR_W = 24;

    localparam logic [31:0] STATUS_ADDR  = SPI_BASE;
    localparam logic [31:0] CONTROL_ADDR = SPI_BASE + 32'd4;
    localparam logic [31:0] DATA_ADDR    = SPI_BASE + 32'd8;
    localparam logic [IDX_W-1:0] IDX_DATA = IDX_W'(4);

    typedef enum logic [3:0] {
        S_IDLE, S_ZERO, S_CFG, S_LOAD, S_START, S_CLEAR,
        S_WAIT, S_POLL, S_READ, S_EMIT, S_END, S_GAP
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LEN_W-1:0]    rem_q;
    logic [3:0]          clkdiv_q;
    logic [IDX_W-1:0]    idx_q;
    logic [IDX_W-1:0]    idx_d;
    logic [CNT_W-1:0]    cnt_q;

    logic                cmd_ready_q;
    logic                cs_n_q;
    logic                rx_valid_q;
    logic [7:0]          rx_data_q;
    logic                done_q;
    logic [31:0]         spi_addr_q;
    logic [31:0]         spi_wdata_q;
    logic [3:0]          spi_wmask_q;
    logic                spi_wen_q;
    logic                spi_ren_q;

    logic                unused_rdata;
    assign unused_rdata = ^{spi_rdata[31:16], spi_rdata[7:2]};

    // Byte index saturates once it reaches the dummy/data region.
    assign idx_d = (idx_q == IDX_DATA) ? idx_q : idx_q + IDX_W'(1);

    function automatic logic [7:0] tx_byte(input logic [IDX_W-1:0] idx,
                                           input logic [ADDR_W-1:0] a);
        case (idx)
            IDX_W'(0): tx_byte = READ_OPCODE;
            IDX_W'(1): tx_byte = a[23:16];
            IDX_W'(2): tx_byte = a[15:8];
            IDX_W'(3): tx_byte = a[7:0];
            default:   tx_byte = 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] ctrl_word(input logic [3:0] div, input logic start);
        ctrl_word = {26'b0, div, 1'b0, start};
    endfunction

    // Outputs are loaded on the edge that enters a state, so each state's
    // bus access is visible during that state's own cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            clkdiv_q    <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            cs_n_q      <= 1'b1;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            done_q      <= 1'b0;
            spi_addr_q  <= '0;
            spi_wdata_q <= '0;
            spi_wmask_q <= '0;
            spi_wen_q   <= 1'b0;
            spi_ren_q   <= 1'b0;
        end else begin
            spi_wen_q <= 1'b0;
            spi_ren_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        addr_q      <= cmd_addr;
                        rem_q       <= cmd_len;
                        clkdiv_q    <= cmd_clkdiv;
                        idx_q       <= '0;
                        cmd_ready_q <= 1'b0;
                        if (cmd_len == LEN_W'(0)) begin
                            done_q  <= 1'b1;
                            state_q <= S_ZERO;
                        end else begin
                            cs_n_q      <= 1'b0;
                            spi_wen_q   <= 1'b1;
                            spi_addr_q  <= CONTROL_ADDR;
                            spi_wdata_q <= ctrl_word(cmd_clkdiv, 1'b0);
                            spi_wmask_q <= 4'b0001;
                            state_q     <= S_CFG;
                        end
                    end
                end
                S_ZERO: begin
                    cmd_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                S_CFG: begin
                    spi_wen_q   <= 1'b1;
                    spi_addr_q  <= DATA_ADDR;
                    spi_wdata_q <= {24'b0, tx_byte(idx_q, addr_q)};
                    state_q     <= S_LOAD;
                end
                S_LOAD: begin
                    spi_wen_q   <= 1'b1;
                    spi_addr_q  <= CONTROL_ADDR;
                    spi_wdata_q <= ctrl_word(clkdiv_q, 1'b1);
                    state_q     <= S_START;
                end
                S_START: begin
                    spi_wen_q   <= 1'b1;
                    spi_addr_q  <= CONTROL_ADDR;
                    spi_wdata_q <= ctrl_word(clkdiv_q, 1'b0);
                    state_q     <= S_CLEAR;
                end
                S_CLEAR: begin
                    cnt_q   <= CNT_W'(START_WAIT - 1);
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_q == CNT_W'(0)) begin
                        spi_ren_q  <= 1'b1;
                        spi_addr_q <= STATUS_ADDR;
                        state_q    <= S_POLL;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_POLL: begin
                    spi_ren_q <= 1'b1;
                    if (!spi_rdata[1] && spi_rdata[0]) begin
                        spi_addr_q <= DATA_ADDR;
                        state_q    <= S_READ;
                    end else begin
                        spi_addr_q <= STATUS_ADDR;
                    end
                end
                S_READ: begin
                    if (idx_q < IDX_DATA) begin
                        idx_q       <= idx_d;
                        spi_wen_q   <= 1'b1;
                        spi_addr_q  <= DATA_ADDR;
                        spi_wdata_q <= {24'b0, tx_byte(idx_d, addr_q)};
                        state_q     <= S_LOAD;
                    end else begin
                        rx_valid_q <= 1'b1;
                        rx_data_q  <= spi_rdata[15:8];
                        state_q    <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (rx_ready) begin
                        rx_valid_q <= 1'b0;
                        if (rem_q == LEN_W'(1)) begin
                            cs_n_q  <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_END;
                        end else begin
                            rem_q       <= rem_q - LEN_W'(1);
                            idx_q       <= idx_d;
                            spi_wen_q   <= 1'b1;
                            spi_addr_q  <= DATA_ADDR;
                            spi_wdata_q <= {24'b0, tx_byte(idx_d, addr_q)};
                            state_q     <= S_LOAD;
                        end
                    end
                end
                S_END: begin
                    cnt_q   <= CNT_W'(CS_GAP - 1);
                    state_q <= S_GAP;
                end
                S_GAP: begin
                    if (cnt_q == CNT_W'(0)) begin
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    cs_n_q      <= 1'b1;
                    rx_valid_q  <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign cs_n      = cs_n_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign done      = done_q;
    assign spi_addr  = spi_addr_q;
    assign spi_wdata = spi_wdata_q;
    assign spi_wmask = spi_wmask_q;
    assign spi_wen   = spi_wen_q;
    assign spi_ren   = spi_ren_q;

endmodule

// File: doc/spi_flash_read_seq.md
Name: spi_flash_read_seq

Overview:
- Bus-master sequencer that drives the memory-mapped SPI controller (STATUS/CONTROL/DATA registers) to run a complete SPI-flash READ (opcode 0x03) transaction.
- Accepts one command: 24-bit flash address plus byte count. Owns chip select. Streams the received bytes out over a valid/ready interface.
- Sits between the boot/DMA logic and the SPI controller, replacing CPU polling loops.

Parameters:
SPI_BASE, 32'hd000, base address of SPI controller; STATUS=+0, CONTROL=+4, DATA=+8
READ_OPCODE, 8'h03, first byte sent in every transaction
START_WAIT, 2, idle cycles after tx_start rises before the first STATUS poll (≥2)
CS_GAP, 4, clk cycles cs_n held high after a transaction before cmd_ready returns

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  sequencer idle, accepts command
cmd_addr  input  24  flash byte address, sent MSB first
cmd_len  input  16  data bytes to read; 0 = no transaction
cmd_clkdiv  input  4  value written to CONTROL[5:2]
rx_valid  output  1  received data byte available
rx_data  output  8  received byte
rx_ready  input  1  consumer accepts byte
done  output  1  one-cycle pulse when a command completes
cs_n  output  1  flash chip select, active low
spi_addr  output  32  bus address to SPI controller
spi_wdata  output  32  bus write data
spi_wmask  output  4  byte write mask
spi_wen  output  1  bus write strobe
spi_ren  output  1  bus read strobe
spi_rdata  input  32  combinational read data from SPI controller

Behaviour:
- Reset (async):
  - state IDLE; cmd_ready=1; cs_n=1.
  - rx_valid, done, spi_wen and spi_ren are 0; spi_addr, spi_wdata and spi_wmask are 0.
  - Counters cleared. Reset mid-transaction aborts immediately; no done pulse.
- Bus: at most one access per cycle. Writes complete in their cycle (controller ready=1). A read samples spi_rdata in the same cycle ren=1.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch addr/len/clkdiv and drop cmd_ready.
  - len==0: pulse done on the next cycle, return to IDLE; cs_n is never asserted.
  - len!=0: go to CFG.
- CFG: write CONTROL = {26'b0, clkdiv, reset=0, start=0}, wmask=4'b0001. Assert cs_n=0 in the same cycle. Next state LOAD; byte index=0.
- Byte sequence, indices 0..3 then 4..len+3: index 0 = READ_OPCODE; 1..3 = addr[23:16], addr[15:8], addr[7:0]; ≥4 = 8'h00 dummy.
  - LOAD: write DATA byte0 = tx byte, wmask=4'b0001.
  - START: write CONTROL with start=1.
  - CLEAR: write CONTROL with start=0.
  - WAIT: START_WAIT idle cycles.
  - POLL: read STATUS every cycle until bit1 (busy)==0 and bit0 (finished)==1, then go to READ.
  - READ: read DATA; capture spi_rdata[15:8].
  - Index <4: discard the byte, index++, go to LOAD.
  - Index ≥4: go to EMIT.
- EMIT: rx_valid=1 with rx_data held stable until rx_valid&rx_ready; no SPI activity meanwhile.
  - On handshake: if remaining==1, go to END; else remaining--, index++, go to LOAD.
  - Remaining is 16-bit, so 65535 bytes must work without wrap.
- END: cs_n=1 and done=1 for one cycle. Then hold cs_n high for CS_GAP cycles with cmd_ready=0, then IDLE.
- Index counter saturates at 4 (no wrap). cmd_valid while busy is ignored (cmd_ready=0).
- Minimum per-byte latency, LOAD to READ: 4 + START_WAIT + polls.

Test Plan:
1. Reset: hold rst mid-POLL, index 5 → same cycle cs_n=1, rx_valid=0, spi_wen=spi_ren=0. After release cmd_ready=1 and no done pulse.
2. Basic read: addr=24'h012345, len=2, clkdiv=3, flash model returns 0xA5 then 0x3C → MOSI 03 01 23 45 00 00. rx bytes A5 then 3C. One done pulse; cs_n low throughout those 6 bytes only.
3. Zero length: len=0 → done one cycle after accept. cs_n stays 1; no spi_wen/spi_ren.
4. Backpressure: len=3, rx_ready low 20 cycles on the 2nd byte → rx_data stable, no DATA write until the handshake, all 3 bytes correct.
5. Fast clock: clkdiv=0, len=4, address 0xFFFFFF → 8 bytes transferred. Each START write preceded by a start=0 write; rx values match the model.
6. Command while busy: cmd_valid asserted during transaction → ignored. Accepted only after CS_GAP=4 cycles post-done.
